// File: rtl/msdf_pkg.sv
// Shared constants for the MSDF operand serializer: digit codes for both
// redundant encodings and the stream FSM states.
package msdf_pkg;

   localparam logic [1:0] SD_PLUS1   = 2'b10;
   localparam logic [1:0] SD_MINUS1  = 2'b01;
   localparam logic [1:0] BS_PLUS1   = 2'b01;
   localparam logic [1:0] BS_MINUS1  = 2'b11;
   localparam logic [1:0] DIGIT_ZERO = 2'b00;

   localparam logic [1:0] MODE_SD   = 2'd0;
   localparam logic [1:0] MODE_BS   = 2'd1;
   localparam logic [1:0] MODE_NONE = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

endpackage

// File: rtl/msdf_digit_encoder.sv
// Maps one two's-complement operand bit to a 2-bit redundant digit; the sign
// bit carries weight -1, every other bit weight +1.
module msdf_digit_encoder
   import msdf_pkg::*;
#(
   parameter string ENCODING_MODE = "signed-digit"
) (
   input  logic       i_bit,
   input  logic       i_is_msb,
   output logic [1:0] o_digit
);

   localparam logic [1:0] MODE = (ENCODING_MODE == "signed-digit") ? MODE_SD :
                                 (ENCODING_MODE == "borrow-save")  ? MODE_BS : MODE_NONE;

   // Digit lookup for the selected encoding; unknown encodings emit zero digits.
   always_comb begin
      o_digit = DIGIT_ZERO;
      case (MODE)
         MODE_SD: begin
            if (!i_bit) begin
               o_digit = DIGIT_ZERO;
            end else if (i_is_msb) begin
               o_digit = SD_MINUS1;
            end else begin
               o_digit = SD_PLUS1;
            end
         end
         MODE_BS: begin
            if (!i_bit) begin
               o_digit = DIGIT_ZERO;
            end else if (i_is_msb) begin
               o_digit = BS_MINUS1;
            end else begin
               o_digit = BS_PLUS1;
            end
         end
         default: o_digit = DIGIT_ZERO;
      endcase
   end

endmodule

// File: rtl/msdf_operand_serializer.sv
// Serializes parallel (X, Y) operand pairs MSD-first as redundant digit
// streams, with one pending slot so consecutive streams run without a gap.
module msdf_operand_serializer
   import msdf_pkg::*;
#(
   parameter string      ENCODING_MODE = "signed-digit",
   parameter logic [7:0] DIGITS        = 8'd16,
   parameter logic [7:0] POINT_POS     = 8'd0
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_op_valid,
   output logic              o_op_ready,
   input  logic [DIGITS-1:0] i_op_x,
   input  logic [DIGITS-1:0] i_op_y,
   output logic              o_mbus_wen,
   output logic [1:0]        o_mbus_wdata_x,
   output logic [1:0]        o_mbus_wdata_y,
   output logic              o_mbus_wpoint,
   output logic              o_mbus_wvalid,
   output logic              o_mbus_wlast,
   input  logic              i_mbus_wstop,
   input  logic              i_mbus_wclr
);

   localparam int unsigned   CW        = (DIGITS > 8'd1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_IDX  = CW'(DIGITS - 8'd1);
   localparam logic [CW-1:0] POINT_IDX = CW'(POINT_POS);
   localparam logic          POINT_OK  = (POINT_POS < DIGITS);

   state_e              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic                r_pending, w_pending_nxt;
   logic                r_alive;
   logic [DIGITS-1:0]   r_act_x, r_act_y, w_act_x_nxt, w_act_y_nxt;
   logic [DIGITS-1:0]   r_pend_x, r_pend_y, w_pend_x_nxt, w_pend_y_nxt;

   logic                w_sending, w_wvalid, w_last_digit, w_ready, w_accept, w_is_msb;
   logic [1:0]          w_dig_x, w_dig_y;

   assign w_sending    = (r_state == ST_SEND);
   assign w_wvalid     = w_sending & ~i_mbus_wstop;
   assign w_last_digit = w_wvalid & (r_cnt == LAST_IDX);
   // r_alive keeps ready low while reset is held and until the first clock after release.
   assign w_ready      = r_alive & ~r_pending & ~i_mbus_wclr;
   assign w_accept     = i_op_valid & w_ready;
   assign w_is_msb     = (r_cnt == {CW{1'b0}});

   msdf_digit_encoder #(.ENCODING_MODE(ENCODING_MODE)) u_enc_x (
      .i_bit    (r_act_x[DIGITS-1]),
      .i_is_msb (w_is_msb),
      .o_digit  (w_dig_x)
   );

   msdf_digit_encoder #(.ENCODING_MODE(ENCODING_MODE)) u_enc_y (
      .i_bit    (r_act_y[DIGITS-1]),
      .i_is_msb (w_is_msb),
      .o_digit  (w_dig_y)
   );

   // Next-state logic: clear dominates, then stream advance, promotion and acceptance.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      w_act_x_nxt   = r_act_x;
      w_act_y_nxt   = r_act_y;
      w_pend_x_nxt  = r_pend_x;
      w_pend_y_nxt  = r_pend_y;
      if (i_mbus_wclr) begin
         w_state_nxt   = ST_IDLE;
         w_cnt_nxt     = {CW{1'b0}};
         w_pending_nxt = 1'b0;
         w_act_x_nxt   = {DIGITS{1'b0}};
         w_act_y_nxt   = {DIGITS{1'b0}};
         w_pend_x_nxt  = {DIGITS{1'b0}};
         w_pend_y_nxt  = {DIGITS{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_act_x_nxt = i_op_x;
                  w_act_y_nxt = i_op_y;
                  w_cnt_nxt   = {CW{1'b0}};
                  w_state_nxt = ST_SEND;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_SEND: begin
               if (w_accept && !w_last_digit) begin
                  w_pend_x_nxt  = i_op_x;
                  w_pend_y_nxt  = i_op_y;
                  w_pending_nxt = 1'b1;
               end else begin
                  w_pending_nxt = r_pending;
               end
               if (w_last_digit) begin
                  w_cnt_nxt = {CW{1'b0}};
                  if (r_pending) begin
                     w_act_x_nxt   = r_pend_x;
                     w_act_y_nxt   = r_pend_y;
                     w_pending_nxt = 1'b0;
                  end else if (w_accept) begin
                     w_act_x_nxt = i_op_x;
                     w_act_y_nxt = i_op_y;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else if (w_wvalid) begin
                  w_act_x_nxt = {r_act_x[DIGITS-2:0], 1'b0};
                  w_act_y_nxt = {r_act_y[DIGITS-2:0], 1'b0};
                  w_cnt_nxt   = r_cnt + CW'(1'b1);
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = {CW{1'b0}};
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CW{1'b0}};
         r_pending <= 1'b0;
         r_alive   <= 1'b0;
         r_act_x   <= {DIGITS{1'b0}};
         r_act_y   <= {DIGITS{1'b0}};
         r_pend_x  <= {DIGITS{1'b0}};
         r_pend_y  <= {DIGITS{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         r_alive   <= 1'b1;
         r_act_x   <= w_act_x_nxt;
         r_act_y   <= w_act_y_nxt;
         r_pend_x  <= w_pend_x_nxt;
         r_pend_y  <= w_pend_y_nxt;
      end
   end

   assign o_op_ready     = w_ready;
   assign o_mbus_wen     = w_sending;
   assign o_mbus_wvalid  = w_wvalid;
   assign o_mbus_wlast   = w_last_digit;
   assign o_mbus_wpoint  = POINT_OK & w_wvalid & (r_cnt == POINT_IDX);
   assign o_mbus_wdata_x = w_sending ? w_dig_x : DIGIT_ZERO;
   assign o_mbus_wdata_y = w_sending ? w_dig_y : DIGIT_ZERO;

endmodule

// File: tb/tb_msdf_operand_serializer.sv
// Self-checking bench: directed scenarios plus random traffic checked against
// a queue-based reference model of the operand streams.
module tb_msdf_operand_serializer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       op_valid, stop, clr;
   logic [3:0] op_x, op_y;
   logic       o_ready, o_wen, o_wvalid, o_wlast, o_wpoint;
   logic [1:0] o_wx, o_wy;

   logic       b_valid, b_stop, b_clr;
   logic [3:0] b_x, b_y;
   logic       b_ready, b_wen, b_wvalid, b_wlast, b_wpoint;
   logic [1:0] b_wx, b_wy;

   logic [8:0] obs;
   int         checks = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   assign obs = {o_ready, o_wen, o_wvalid, o_wx, o_wy, o_wlast, o_wpoint};

   msdf_operand_serializer #(.ENCODING_MODE("signed-digit"), .DIGITS(8'd4), .POINT_POS(8'd0)) dut_sd (
      .i_clk(clk), .i_rstn(rst_n), .i_op_valid(op_valid), .o_op_ready(o_ready),
      .i_op_x(op_x), .i_op_y(op_y), .o_mbus_wen(o_wen), .o_mbus_wdata_x(o_wx),
      .o_mbus_wdata_y(o_wy), .o_mbus_wpoint(o_wpoint), .o_mbus_wvalid(o_wvalid),
      .o_mbus_wlast(o_wlast), .i_mbus_wstop(stop), .i_mbus_wclr(clr)
   );

   msdf_operand_serializer #(.ENCODING_MODE("borrow-save"), .DIGITS(8'd4), .POINT_POS(8'd2)) dut_bs (
      .i_clk(clk), .i_rstn(rst_n), .i_op_valid(b_valid), .o_op_ready(b_ready),
      .i_op_x(b_x), .i_op_y(b_y), .o_mbus_wen(b_wen), .o_mbus_wdata_x(b_wx),
      .o_mbus_wdata_y(b_wy), .o_mbus_wpoint(b_wpoint), .o_mbus_wvalid(b_wvalid),
      .o_mbus_wlast(b_wlast), .i_mbus_wstop(b_stop), .i_mbus_wclr(b_clr)
   );

   // Digit k (0 = MSD) of a 4-bit two's-complement fraction as -1/0/+1.
   function automatic int digit_of(input logic [3:0] v, input int k);
      if (k == 0) return v[3] ? -1 : 0;
      return v[3-k] ? 1 : 0;
   endfunction

   // Code of a digit value; mode 0 = signed-digit, 1 = borrow-save.
   function automatic logic [1:0] enc(input int d, input int mode);
      if (d == 1)  return (mode == 0) ? 2'b10 : 2'b01;
      if (d == -1) return (mode == 0) ? 2'b01 : 2'b11;
      return 2'b00;
   endfunction

   // Reference model: queue of accepted pairs; head is the stream on the bus.
   logic [3:0] q_x[$];
   logic [3:0] q_y[$];
   int         pos = 0;
   bit         m_alive = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q_x.delete(); q_y.delete(); pos = 0; m_alive = 1'b0;
         end else begin
            bit acc;
            acc = op_valid && m_alive && (q_x.size() < 2) && !clr;
            if (clr) begin
               q_x.delete(); q_y.delete(); pos = 0;
            end else begin
               if (q_x.size() > 0 && !stop) begin
                  pos++;
                  if (pos == D) begin
                     void'(q_x.pop_front()); void'(q_y.pop_front()); pos = 0;
                  end
               end
               if (acc) begin
                  q_x.push_back(op_x); q_y.push_back(op_y);
               end
            end
            m_alive = 1'b1;
         end
      end
   end

   task automatic compute_exp(output logic [8:0] v);
      logic r, w, vl, l, p;
      logic [1:0] dx, dy;
      r  = rst_n && m_alive && (q_x.size() < 2) && !clr;
      w  = rst_n && (q_x.size() > 0);
      vl = w && !stop;
      dx = 2'b00;
      dy = 2'b00;
      if (w) begin
         dx = enc(digit_of(q_x[0], pos), 0);
         dy = enc(digit_of(q_y[0], pos), 0);
      end
      l = vl && (pos == D - 1);
      p = vl && (pos == 0);
      v = {r, w, vl, dx, dy, l, p};
   endtask

   task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                        input logic s, input logic c);
      op_valid = v; op_x = x; op_y = y; stop = s; clr = c;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      @(negedge clk);
      checks++;
      if (obs !== 9'd0) $display("FAIL reset_outputs: got %b expected %b", obs, 9'd0);
      else passed++;
      step();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", o_ready);
      else passed++;
      compute_exp(e);
      checks++;
      if (obs !== e) $display("FAIL reset_model: got %b expected %b", obs, e);
      else passed++;
      step();
   endtask

   task automatic test_basic();
      logic [1:0] ex[4];
      logic [1:0] ey[4];
      logic [8:0] e;
      logic [6:0] got, want;
      ex = '{2'b00, 2'b10, 2'b00, 2'b00};
      ey = '{2'b01, 2'b10, 2'b10, 2'b00};
      drive(1'b1, 4'b0100, 4'b1110, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) $display("FAIL basic_ready: got %b expected 1", o_ready);
      else passed++;
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < D; k++) begin
         @(negedge clk);
         got  = {o_wvalid, o_wx, o_wy, o_wlast, o_wpoint};
         want = {1'b1, ex[k], ey[k], (k == 3), (k == 0)};
         checks++;
         if (got !== want) $display("FAIL basic_digit%0d: got %b expected %b", k, got, want);
         else passed++;
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL basic_model%0d: got %b expected %b", k, obs, e);
         else passed++;
         step();
      end
      @(negedge clk);
      checks++;
      if (o_wen !== 1'b0) $display("FAIL basic_wen_drop: got %b expected 0", o_wen);
      else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] bx, by;
      logic [8:0] e;
      bx = 4'($urandom); by = 4'($urandom);
      drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
      step();
      for (int i = 0; i < 2 * D; i++) begin
         drive(i == 0, bx, by, 1'b0, 1'b0);
         @(negedge clk);
         checks++;
         if ({o_wvalid, o_wlast} !== {1'b1, (i == 3 || i == 7)})
            $display("FAIL b2b_valid_last%0d: got %b%b expected 1%b", i, o_wvalid, o_wlast, (i == 3 || i == 7));
         else passed++;
         checks++;
         if (o_ready !== (i == 0 || i >= 4)) $display("FAIL b2b_ready%0d: got %b expected %b", i, o_ready, (i == 0 || i >= 4));
         else passed++;
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL b2b_model%0d: got %b expected %b", i, obs, e);
         else passed++;
         step();
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (o_wen !== 1'b0) $display("FAIL b2b_end: got %b expected 0", o_wen);
      else passed++;
      step();
   endtask

   task automatic test_stall();
      logic [3:0] ax, ay;
      logic [8:0] e;
      logic       s;
      ax = 4'($urandom); ay = 4'($urandom);
      drive(1'b1, ax, ay, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 7; i++) begin
         s = (i >= 2 && i <= 4);
         drive(1'b0, 4'd0, 4'd0, s, 1'b0);
         @(negedge clk);
         checks++;
         if ({o_wen, o_wvalid, o_wlast} !== {1'b1, !s, (i == 6)})
            $display("FAIL stall_ctl%0d: got %b expected %b", i, {o_wen, o_wvalid, o_wlast}, {1'b1, !s, (i == 6)});
         else passed++;
         if (i >= 2 && i <= 5) begin
            checks++;
            if ({o_wx, o_wy} !== {enc(digit_of(ax, 2), 0), enc(digit_of(ay, 2), 0)})
               $display("FAIL stall_hold%0d: got %b expected %b", i, {o_wx, o_wy}, {enc(digit_of(ax, 2), 0), enc(digit_of(ay, 2), 0)});
            else passed++;
         end
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL stall_model%0d: got %b expected %b", i, obs, e);
         else passed++;
         step();
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (o_wen !== 1'b0) $display("FAIL stall_length: got %b expected 0", o_wen);
      else passed++;
      step();
   endtask

   task automatic test_clear();
      logic [3:0] dx, dy;
      logic [8:0] e;
      dx = 4'($urandom); dy = 4'($urandom);
      drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
      step();
      drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
      step();
      drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b0) $display("FAIL clear_ready: got %b expected 0", o_ready);
      else passed++;
      step();
      drive(1'b1, dx, dy, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({o_wen, o_wx, o_wy, o_ready} !== 6'b000001)
         $display("FAIL clear_after: got %b expected 000001", {o_wen, o_wx, o_wy, o_ready});
      else passed++;
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < D; k++) begin
         @(negedge clk);
         checks++;
         if ({o_wvalid, o_wx, o_wy} !== {1'b1, enc(digit_of(dx, k), 0), enc(digit_of(dy, k), 0)})
            $display("FAIL clear_restream%0d: got %b expected %b", k, {o_wvalid, o_wx, o_wy},
                     {1'b1, enc(digit_of(dx, k), 0), enc(digit_of(dy, k), 0)});
         else passed++;
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL clear_model%0d: got %b expected %b", k, obs, e);
         else passed++;
         step();
      end
      @(negedge clk);
      checks++;
      if (o_wen !== 1'b0) $display("FAIL clear_discard: got %b expected 0", o_wen);
      else passed++;
      step();
   endtask

   task automatic test_borrow_save();
      logic [1:0] bsx[4];
      logic [3:0] by;
      logic [4:0] got, want;
      bsx = '{2'b11, 2'b00, 2'b00, 2'b01};
      by = 4'($urandom);
      b_valid = 1'b1; b_x = 4'b1001; b_y = by;
      step();
      b_valid = 1'b0;
      for (int k = 0; k < D; k++) begin
         @(negedge clk);
         got  = {b_wvalid, b_wx, b_wlast, b_wpoint};
         want = {1'b1, bsx[k], (k == 3), (k == 2)};
         checks++;
         if (got !== want) $display("FAIL bs_x%0d: got %b expected %b", k, got, want);
         else passed++;
         checks++;
         if (b_wy !== enc(digit_of(by, k), 1)) $display("FAIL bs_y%0d: got %b expected %b", k, b_wy, enc(digit_of(by, k), 1));
         else passed++;
         step();
      end
      @(negedge clk);
      checks++;
      if (b_wen !== 1'b0) $display("FAIL bs_end: got %b expected 0", b_wen);
      else passed++;
      step();
   endtask

   task automatic test_random();
      logic [8:0] e;
      for (int n = 0; n < 400; n++) begin
         drive(($urandom % 4) != 0, 4'($urandom), 4'($urandom), ($urandom % 4) == 0, ($urandom % 32) == 0);
         @(negedge clk);
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL random%0d: got %b expected %b", n, obs, e);
         else passed++;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] e;
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      step();
      drive(1'b1, 4'($urandom) | 4'b0100, 4'($urandom), 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      step();
      @(negedge clk);
      compute_exp(e);
      checks++;
      if (obs !== e || pos != 2) $display("FAIL rstmid_pre: got %b expected %b at digit 2", obs, e);
      else passed++;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 9'd0) $display("FAIL rstmid_async: got %b expected %b", obs, 9'd0);
      else passed++;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({o_wen, o_wvalid} !== 2'b00) $display("FAIL rstmid_spurious%0d: got %b expected 00", i, {o_wen, o_wvalid});
         else passed++;
         compute_exp(e);
         checks++;
         if (obs !== e) $display("FAIL rstmid_model%0d: got %b expected %b", i, obs, e);
         else passed++;
         step();
      end
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", o_ready);
      else passed++;
      step();
   endtask

   initial begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      b_valid = 1'b0; b_x = 4'd0; b_y = 4'd0; b_stop = 1'b0; b_clr = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_clear();
      test_borrow_save();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
